// File: rtl/pipeline_control.sv
// pipeline_control: stall/flush sequencer for a 5-stage pipeline with redirect bubbles and halt drain/park.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipeline_control #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_stall,
  input  logic        ex_branch_taken,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);
  typedef enum logic [1:0] {RUN, REDIRECT, DRAIN, HALTED} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic redirect, drain_adv;
  assign ctrl_state = state;
  assign drain_adv = state == DRAIN;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    redirect = 1'b0;
    pc_en = 1'b1;
    if_id_en = 1'b1;
    id_ex_en = 1'b1;
    ex_mem_en = 1'b1;
    mem_wb_en = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      state_n = RUN;
      cnt_n = '0;
    end else if (state == HALTED || mem_busy) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      if (state == HALTED && resume_req) state_n = RUN;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redirect = 1'b1;
      if (drain_adv) begin
        cnt_n = cnt + 4'd1;
        state_n = cnt == 4'(DRAIN_CYCLES - 1) ? HALTED : DRAIN;
      end else begin
        state_n = REDIRECT_BUBBLES > 1 ? REDIRECT : RUN;
        cnt_n = 4'(REDIRECT_BUBBLES - 1);
      end
    end else if (state == REDIRECT) begin
      if_id_flush = 1'b1;
      cnt_n = cnt - 4'd1;
      state_n = cnt == 4'd1 ? RUN : REDIRECT;
    end else if (state == DRAIN || halt_req) begin
      // halt entry already drives drain outputs; the ID instruction still proceeds
      pc_en = 1'b0;
      if_id_en = !load_use_stall;
      if_id_flush = !load_use_stall;
      id_ex_flush = load_use_stall;
      if (state == RUN) begin
        state_n = DRAIN;
        cnt_n = '0;
      end else if (!load_use_stall) begin
        cnt_n = cnt + 4'd1;
        state_n = cnt == 4'(DRAIN_CYCLES - 1) ? HALTED : DRAIN;
      end
    end else if (load_use_stall) begin
      pc_en = 1'b0;
      if_id_en = 1'b0;
      id_ex_flush = 1'b1;
    end else if (if_busy) begin
      pc_en = 1'b0;
      if_id_flush = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    state <= rst ? RUN : state_n;
    cnt <= rst ? '0 : cnt_n;
    halted <= !rst && state_n == HALTED;
  end
`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_en && state != HALTED) stall_cycles <= stall_cycles + 32'd1;
      if (redirect) flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central stall/flush sequencer for one core's 5-stage pipeline (IF, ID, EX, MEM, WB).
- Merges four stall/redirect sources into per-register enable and flush controls:
  - the decode-stage load-use stall
  - the EX-stage taken-branch redirect
  - instruction-fetch not-ready
  - data-memory not-ready
- Owns a small FSM that holds redirect bubbles and drains/parks the core on a halt request. Multicore sync logic uses the park/resume for per-core parking.

Parameters:
- REDIRECT_BUBBLES, 1, cycles IF/ID is flushed after a taken branch (1..7); the value 1 means the flush cycle only.
- DRAIN_CYCLES, 4, advancing cycles needed to empty IF/ID through MEM/WB before HALTED (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- load_use_stall  in  1  load-use hazard for the instruction in ID.
- ex_branch_taken  in  1  EX-stage instruction redirects the PC; PC mux selects target.
- if_busy  in  1  instruction fetch has no valid word this cycle.
- mem_busy  in  1  data memory has not completed the MEM-stage access.
- halt_req  in  1  level; park the core; held until halted=1.
- resume_req  in  1  pulse; leave HALTED.
- pc_en  out  1  PC register load enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
- if_id_flush, id_ex_flush  out  1 each  load NOP/bubble instead of data; only meaningful when the matching enable is 1.
- halted  out  1  core parked, pipeline empty.
- ctrl_state  out  2  FSM state (debug): 0 RUN, 1 REDIRECT, 2 DRAIN, 3 HALTED.
- stall_cycles  out  32  perf counter (see Optional Feature).
- flush_count  out  32  perf counter (see Optional Feature).

Behaviour:
- Control outputs are combinational from the current state and inputs; state, counter and halted are registered.
- Clock is clk; reset rst is synchronous, active-high.
- Reset:
  - State=RUN, cnt=0, halted=0.
  - While rst=1: all enables=1, all flushes=0. Pipeline registers reset via their own rst.
- Default (RUN, no events): all enables 1, flushes 0.
- Priority per cycle, highest first:
  1. mem_busy=1: all five enables 0, flushes 0; FSM and cnt frozen; every other input ignored.
  2. ex_branch_taken=1: pc_en=1, if_id_flush=1, id_ex_flush=1, all enables 1; flush_count+1.
     - If REDIRECT_BUBBLES>1: go to REDIRECT with cnt=REDIRECT_BUBBLES-1.
  3. load_use_stall=1: pc_en=0, if_id_en=0, id_ex_flush=1, others 1.
  4. if_busy=1: pc_en=0, if_id_flush=1, others 1.
- REDIRECT state:
  - pc_en=1, if_id_flush=1; load_use_stall masked.
  - cnt decrements each non-mem_busy cycle; at cnt==1 with a decrement, return to RUN.
  - A new ex_branch_taken reloads cnt and counts again in flush_count.
- Halt entry: in RUN only, halt_req=1 with no mem_busy and no ex_branch_taken → DRAIN, cnt=0. The same cycle already applies DRAIN outputs.
- DRAIN state:
  - pc_en=0, if_id_flush=1; instruction already in ID continues normally.
  - cnt increments only on cycles with mem_busy=0 and load_use_stall=0. Load-use applies rule 3 and holds cnt.
  - ex_branch_taken: pc_en=1 (capture target), if_id_flush=id_ex_flush=1; cnt still advances.
  - When cnt reaches DRAIN_CYCLES-1 on an advancing cycle → HALTED.
- HALTED state:
  - halted=1; all enables 0; flushes 0; all event inputs ignored.
  - resume_req=1 → RUN next cycle with halted=0.
  - halt_req deasserting alone does not resume.
- resume_req outside HALTED and halt_req outside RUN: ignored.
- Reset mid-DRAIN or mid-HALTED: returns to RUN immediately with halted=0.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cycles counts cycles with pc_en=0 outside HALTED.
  - flush_count counts accepted redirects.
  - Both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: both ports are driven constant 0 and no counter flops exist. Control behaviour is identical either way.

Test Plan:
- Idle RUN, all inputs 0 → all enables 1, flushes 0, ctrl_state=0 for 10 cycles.
- load_use_stall=1 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; defaults next cycle.
- REDIRECT_BUBBLES=3, ex_branch_taken pulse → 3 consecutive cycles with if_id_flush=1, then RUN; flush_count=1.
- ex_branch_taken=1 and mem_busy=1 for 2 cycles, then mem_busy=0 → 2 frozen cycles (all enables 0), then the redirect is applied once.
- halt_req=1 with DRAIN_CYCLES=4 and one load_use_stall during drain → halted=1 after exactly 5 cycles in DRAIN; resume_req pulse → RUN, halted=0 next cycle.
- rst=1 asserted while HALTED → next cycle ctrl_state=0, halted=0, perf counters 0 (macro defined).
